// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: loader FSM state encoding, default bus widths
// and program RAM geometry.
// Optional feature macro: RAM_LOADER_CHECKSUM_EN. When it is defined, the
// state list gains ST_CSUM.
package sap1_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int RAM_DEPTH  = 16;
    localparam int MAX_LEN    = 16;

    // The length down-counter must hold MAX_LEN itself, not just MAX_LEN-1.
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
`ifdef RAM_LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } load_state_t;

    // A session length is usable when it is non-zero and fits the RAM.
    function automatic logic len_ok(input int unsigned n);
        return (n >= 1) && (n <= MAX_LEN) && (n <= RAM_DEPTH);
    endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream handshake plus program-RAM write port of the SAP-1 loader.
// The slave modport is the loader. The master modport is the host side,
// which drives the stream and observes the RAM writes.
interface ram_loader_if #(
    parameter int ADDR_W = sap1_pkg::ADDR_W_DEF,
    parameter int DATA_W = sap1_pkg::DATA_W_DEF
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output ld_valid, ld_data,
        input  ld_ready, prog_we, prog_addr, prog_data
    );

    modport slave (
        input  ld_valid, ld_data,
        output ld_ready, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/ram_loader_csum.sv
// Running mod-2^DATA_W sum of the payload bytes of one load session.
// This module is instantiated only when RAM_LOADER_CHECKSUM_EN is defined.
module ram_loader_csum #(
    parameter int DATA_W = sap1_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    // Accumulate each accepted payload byte; start of session clears the sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// SAP-1 program RAM loader. It takes a length byte N, then N payload bytes,
// and writes the payload bytes to RAM addresses 0..N-1. The CPU is held in
// reset until the load completes.
// Optional feature macro: RAM_LOADER_CHECKSUM_EN. When it is defined, a
// trailing mod-256 checksum byte must match the sum of the payload bytes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; waits for start
// LEN     | waits for the length byte N
// DATA    | accepts N payload bytes, one RAM write per byte
// CSUM    | waits for the checksum byte (only with RAM_LOADER_CHECKSUM_EN)
// DONE    | load complete, CPU released; waits for start
// ERR     | load aborted, CPU held; waits for start
module ram_loader
    import sap1_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    ram_loader_if.slave  bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    load_state_t       state_q;
    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [LEN_W-1:0]  rem_q;
    logic              done_q;
    logic              err_q;
    logic              hold_q;
    logic              acc;

    assign acc = bus.ld_valid & ready_q;

    assign bus.ld_ready  = ready_q;
    assign bus.prog_we   = we_q;
    assign bus.prog_addr = addr_q;
    assign bus.prog_data = data_q;
    assign cpu_hold      = hold_q;
    assign done          = done_q;
    assign err           = err_q;

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              csum_clr;
    logic              csum_add;

    assign csum_clr = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERR));
    assign csum_add = acc && (state_q == ST_DATA);

    ram_loader_csum #(.DATA_W(DATA_W)) u_csum (
        .clk   (clk),
        .reset (reset),
        .clr   (csum_clr),
        .add   (csum_add),
        .din   (bus.ld_data),
        .sum   (csum)
    );
`endif

    // Session FSM. All outputs are registered and change with the state.
    // prog_we defaults low each cycle, so every write is a single-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q  <= ST_LEN;
                        ready_q  <= 1'b1;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        hold_q   <= 1'b1;
                        wr_ptr_q <= '0;
                        rem_q    <= '0;
                    end
                end
                ST_LEN: begin
                    if (acc) begin
                        if (len_ok(32'(bus.ld_data))) begin
                            rem_q   <= LEN_W'(bus.ld_data);
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_ERR;
                            ready_q <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (acc) begin
                        we_q     <= 1'b1;
                        addr_q   <= wr_ptr_q;
                        data_q   <= bus.ld_data;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        rem_q    <= rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                            state_q <= ST_CSUM;
`else
                            state_q <= ST_DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef RAM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (acc) begin
                        ready_q <= 1'b0;
                        if (bus.ld_data == csum) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    hold_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader. It covers reset, a normal session, bad
// lengths, a 16-byte back-to-back burst, a stream with gaps, an abort by
// reset, and the checksum path when RAM_LOADER_CHECKSUM_EN is defined.
module tb_ram_loader;
    import sap1_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic cpu_hold, done, err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];

    ram_loader_if bus ();

    ram_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every RAM write, and check that done and err are never high together.
    always @(negedge clk) begin
        if (bus.prog_we === 1'b1) begin
            wr_addr_q.push_back(bus.prog_addr);
            wr_data_q.push_back(bus.prog_data);
            wr_cyc_q.push_back(cyc);
        end
        n_checks++;
        if ((done & err) !== 1'b0) begin
            n_errors++;
            $display("FAIL done_err_excl: done=%b err=%b at cycle %0d", done, err, cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Holds a byte on the stream until it is accepted. Returns the acceptance
    // cycle in acc. ld_valid is left high, so the caller decides what comes next.
    task automatic send_byte(input logic [7:0] b, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.ld_ready === 1'b1) begin
                acc = cyc;
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (acc < 0) begin
            n_errors++;
            $display("FAIL send_timeout: byte %0h got no ld_ready, expected acceptance", b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.prog_we !== 1'b0) begin n_errors++; $display("FAIL rst_prog_we: got %b expected 0", bus.prog_we); end
        n_checks++; if (bus.prog_addr !== 4'h0) begin n_errors++; $display("FAIL rst_prog_addr: got %0h expected 0", bus.prog_addr); end
        n_checks++; if (bus.prog_data !== 8'h00) begin n_errors++; $display("FAIL rst_prog_data: got %0h expected 0", bus.prog_data); end
        n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ld_ready: got %b expected 0", bus.ld_ready); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %b expected 0", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", err); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL rst_cpu_hold: got %b expected 1", cpu_hold); end
        n_checks++; if (dut.state_q !== ST_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        step(2);
        n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL rst_release_idle: ld_ready got %b expected 0", bus.ld_ready); end
    endtask

    task automatic test_normal();
        int a;
        int acc[3];
        logic [7:0] exp_d[3];
        exp_d[0] = 8'h1E; exp_d[1] = 8'h2F; exp_d[2] = 8'hE0;
        clear_log();
        pulse_start();
        send_byte(8'h03, a);
        start = 1'b1;          // start is ignored while a session runs
        send_byte(exp_d[0], acc[0]);
        start = 1'b0;
        send_byte(exp_d[1], acc[1]);
        send_byte(exp_d[2], acc[2]);
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(8'h2D, a);
`endif
        bus.ld_valid = 1'b0;
        step(3);
        n_checks++; if (wr_addr_q.size() !== 3) begin n_errors++; $display("FAIL norm_wr_count: got %0d expected 3", wr_addr_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (wr_addr_q[i] !== 4'(i)) begin n_errors++; $display("FAIL norm_addr[%0d]: got %0h expected %0h", i, wr_addr_q[i], i); end
            n_checks++; if (wr_data_q[i] !== exp_d[i]) begin n_errors++; $display("FAIL norm_data[%0d]: got %0h expected %0h", i, wr_data_q[i], exp_d[i]); end
            n_checks++; if (wr_cyc_q[i] !== acc[i] + 1) begin n_errors++; $display("FAIL norm_latency[%0d]: got cycle %0d expected %0d", i, wr_cyc_q[i], acc[i] + 1); end
        end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL norm_done: got %b expected 1", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL norm_err: got %b expected 0", err); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_errors++; $display("FAIL norm_cpu_hold: got %b expected 0", cpu_hold); end
        n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL norm_ld_ready: got %b expected 0", bus.ld_ready); end
        n_checks++; if (bus.prog_addr !== 4'h2) begin n_errors++; $display("FAIL norm_addr_hold: got %0h expected 2", bus.prog_addr); end
        n_checks++; if (bus.prog_data !== 8'hE0) begin n_errors++; $display("FAIL norm_data_hold: got %0h expected e0", bus.prog_data); end
    endtask

    task automatic test_bad_len();
        int a;
        logic [7:0] lens[2];
        lens[0] = 8'h00;
        lens[1] = 8'h11;
        for (int k = 0; k < 2; k++) begin
            clear_log();
            pulse_start();
            send_byte(lens[k], a);
            bus.ld_valid = 1'b0;
            step(2);
            n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL badlen_%0h_err: got %b expected 1", lens[k], err); end
            n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL badlen_%0h_done: got %b expected 0", lens[k], done); end
            n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL badlen_%0h_cpu_hold: got %b expected 1", lens[k], cpu_hold); end
            n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL badlen_%0h_ld_ready: got %b expected 0", lens[k], bus.ld_ready); end
            n_checks++; if (wr_addr_q.size() !== 0) begin n_errors++; $display("FAIL badlen_%0h_writes: got %0d expected 0", lens[k], wr_addr_q.size()); end
        end
    endtask

    task automatic test_back_to_back();
        int a;
        int acc[16];
        logic [7:0] sum;
        logic [7:0] d;
        sum = 8'h00;
        clear_log();
        pulse_start();
        send_byte(8'h10, a);
        for (int i = 0; i < 16; i++) begin
            d = 8'hA0 + 8'(i);
            sum = sum + d;
            send_byte(d, acc[i]);
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(sum, a);
`endif
        bus.ld_data = 8'h55;   // ld_valid stays high after the session
        step(4);
        bus.ld_valid = 1'b0;
        step(1);
        n_checks++; if (wr_addr_q.size() !== 16) begin n_errors++; $display("FAIL b2b_wr_count: got %0d expected 16", wr_addr_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (wr_addr_q[i] !== 4'(i)) begin n_errors++; $display("FAIL b2b_addr[%0d]: got %0h expected %0h", i, wr_addr_q[i], i); end
            n_checks++; if (wr_data_q[i] !== 8'hA0 + 8'(i)) begin n_errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, wr_data_q[i], 8'hA0 + 8'(i)); end
            n_checks++; if (wr_cyc_q[i] !== acc[0] + 1 + i) begin n_errors++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, wr_cyc_q[i], acc[0] + 1 + i); end
        end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL b2b_done: got %b expected 1", done); end
        n_checks++; if (bus.prog_addr !== 4'hF) begin n_errors++; $display("FAIL b2b_last_addr: got %0h expected f", bus.prog_addr); end
    endtask

    task automatic test_random_valid();
        int a;
        int idx;
        int acc[5];
        logic [7:0] d[5];
        bit v;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; d[4] = 8'h55;
        idx = 0;
        clear_log();
        pulse_start();
        send_byte(8'h05, a);
        for (int c = 0; c < 200 && idx < 5; c++) begin
            v = 1'($urandom_range(0, 1));
            bus.ld_valid = v;
            bus.ld_data  = v ? d[idx] : 8'hEE;
            @(negedge clk);
            if (v && bus.ld_ready === 1'b1) begin
                acc[idx] = cyc;
                idx++;
            end
            @(posedge clk);
            #1;
        end
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'hEE;
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(8'hFF, a);
        bus.ld_valid = 1'b0;
`endif
        step(3);
        n_checks++; if (idx !== 5) begin n_errors++; $display("FAIL rnd_accepted: got %0d expected 5", idx); end
        n_checks++; if (wr_addr_q.size() !== 5) begin n_errors++; $display("FAIL rnd_wr_count: got %0d expected 5", wr_addr_q.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (wr_addr_q[i] !== 4'(i)) begin n_errors++; $display("FAIL rnd_addr[%0d]: got %0h expected %0h", i, wr_addr_q[i], i); end
            n_checks++; if (wr_data_q[i] !== d[i]) begin n_errors++; $display("FAIL rnd_data[%0d]: got %0h expected %0h", i, wr_data_q[i], d[i]); end
            n_checks++; if (wr_cyc_q[i] !== acc[i] + 1) begin n_errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, wr_cyc_q[i], acc[i] + 1); end
        end
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL rnd_done: got %b expected 1", done); end
    endtask

`ifdef RAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int a;
        clear_log();
        pulse_start();
        send_byte(8'h02, a);
        send_byte(8'h10, a);
        send_byte(8'h20, a);
        send_byte(8'h31, a);
        bus.ld_valid = 1'b0;
        step(2);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL csum_bad_err: got %b expected 1", err); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL csum_bad_done: got %b expected 0", done); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL csum_bad_cpu_hold: got %b expected 1", cpu_hold); end
        n_checks++; if (wr_addr_q.size() !== 2) begin n_errors++; $display("FAIL csum_bad_writes: got %0d expected 2", wr_addr_q.size()); end
        clear_log();
        pulse_start();
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL csum_retry_err_clr: got %b expected 0", err); end
        send_byte(8'h02, a);
        send_byte(8'h10, a);
        send_byte(8'h20, a);
        send_byte(8'h30, a);
        bus.ld_valid = 1'b0;
        step(2);
        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL csum_good_done: got %b expected 1", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL csum_good_err: got %b expected 0", err); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_errors++; $display("FAIL csum_good_cpu_hold: got %b expected 0", cpu_hold); end
        n_checks++; if (wr_data_q[1] !== 8'h20) begin n_errors++; $display("FAIL csum_good_data1: got %0h expected 20", wr_data_q[1]); end
    endtask
`endif

    task automatic test_reset_mid_data();
        int a;
        clear_log();
        pulse_start();
        send_byte(8'h08, a);
        send_byte(8'h61, a);
        send_byte(8'h62, a);
        send_byte(8'h63, a);
        bus.ld_data = 8'h99;   // a fourth byte is pending when reset hits
        #2;
        n_checks++; if (bus.prog_we !== 1'b1) begin n_errors++; $display("FAIL mid_pre_we: got %b expected 1", bus.prog_we); end
        n_checks++; if (bus.prog_addr !== 4'h2) begin n_errors++; $display("FAIL mid_pre_addr: got %0h expected 2", bus.prog_addr); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.prog_we !== 1'b0) begin n_errors++; $display("FAIL mid_rst_we: got %b expected 0", bus.prog_we); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL mid_rst_cpu_hold: got %b expected 1", cpu_hold); end
        n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL mid_rst_ld_ready: got %b expected 0", bus.ld_ready); end
        n_checks++; if (dut.state_q !== ST_IDLE) begin n_errors++; $display("FAIL mid_rst_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        n_checks++; if (bus.prog_addr !== 4'h0) begin n_errors++; $display("FAIL mid_rst_addr: got %0h expected 0", bus.prog_addr); end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        step(5);
        bus.ld_valid = 1'b0;
        // The third write pulse is cut by reset before the falling edge, so
        // only the first two writes are logged.
        n_checks++; if (wr_addr_q.size() !== 2) begin n_errors++; $display("FAIL mid_writes: got %0d expected 2", wr_addr_q.size()); end
        n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++; $display("FAIL mid_post_ld_ready: got %b expected 0", bus.ld_ready); end
        n_checks++; if (dut.state_q !== ST_IDLE) begin n_errors++; $display("FAIL mid_post_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL mid_post_cpu_hold: got %b expected 1", cpu_hold); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_len();
        test_back_to_back();
        test_random_valid();
`ifdef RAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_data();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning the RAM address width (16 words).
REQ-002 SHALL have parameter DATA_W, default 8, meaning the RAM word and stream byte width.
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  meaning an asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to begin a load session.
REQ-006 SHALL have port ld_valid  input  1  meaning a stream byte is present on ld_data.
REQ-007 SHALL have port ld_data  input  DATA_W  meaning the stream byte.
REQ-008 SHALL have port ld_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-009 SHALL have port prog_we  output  1  meaning the RAM write strobe toward the SAP-1 program RAM.
REQ-010 SHALL have port prog_addr  output  ADDR_W  meaning the RAM write address.
REQ-011 SHALL have port prog_data  output  DATA_W  meaning the RAM write data.
REQ-012 SHALL have port cpu_hold  output  1  meaning the CPU is held in reset while high.
REQ-013 SHALL have port done  output  1  meaning the load completed successfully.
REQ-014 SHALL have port err  output  1  meaning the load was aborted.

Function
REQ-015 SHALL implement the FSM states IDLE, LEN, DATA, CSUM, DONE and ERR.
REQ-016 SHALL go from IDLE, DONE or ERR to LEN on start, clearing done, err, the byte count and the checksum, and driving cpu_hold=1.
REQ-017 SHALL ignore start while in LEN, DATA or CSUM.
REQ-018 SHALL drive ld_ready=1 only in LEN, DATA and CSUM; a byte is transferred only when ld_valid and ld_ready are both high in the same cycle.
REQ-019 SHALL, in LEN, store the accepted byte as N; N in 1..16 goes to DATA, while N=0 or N>16 goes to ERR.
REQ-020 SHALL, in DATA, for the k-th accepted byte (k=0..N-1), pulse prog_we for exactly one cycle on the cycle after acceptance, with prog_addr=k and prog_data=byte (1-cycle latency).
REQ-021 SHALL write back-to-back when ld_valid stays high, giving one RAM write per cycle with no bubbles.
REQ-022 SHALL wrap the address counter modulo 2^ADDR_W; N=16 writes address 15 last and no overflow write occurs.
REQ-023 SHALL, after the N-th data byte, go to CSUM if CHECKSUM_EN is defined and otherwise to DONE.
REQ-024 SHALL hold prog_addr and prog_data at their last values when prog_we=0.
REQ-025 SHALL, in DONE, drive done=1 and cpu_hold=0 and hold there until start.
REQ-026 SHALL, in ERR, drive err=1 and cpu_hold=1 and hold there until start; RAM contents already written are left as-is.
REQ-027 SHALL never assert done and err together.

Reset
REQ-028 SHALL, while reset=0, immediately force state=IDLE, prog_we=0, prog_addr=0, prog_data=0, ld_ready=0, done=0, err=0 and cpu_hold=1.
REQ-029 SHALL abort a session cleanly on reset mid-load, with no prog_we pulse emitted during or after reset assertion.
REQ-030 SHALL take the first transition no earlier than the first rising clk edge after reset deasserts.

Configuration
REQ-031 SHALL, when RAM_LOADER_CHECKSUM_EN is defined, accumulate the 8-bit mod-256 sum of the data bytes and compare it with the byte accepted in CSUM: equal goes to DONE, unequal goes to ERR.
REQ-032 SHALL, when RAM_LOADER_CHECKSUM_EN is undefined, contain no CSUM state or accumulator logic and expect no trailing byte.

Structure
REQ-033 SHALL take the FSM state enum, ADDR_W/DATA_W defaults, RAM_DEPTH=16 and MAX_LEN=16 from shared package sap1_pkg.
REQ-034 SHALL place the checksum accumulator in one sub-module, ram_loader_csum, instantiated only under RAM_LOADER_CHECKSUM_EN.

Verification
REQ-035 SHALL cover: reset=0 mid-DATA after 3 bytes -> prog_we=0 immediately, cpu_hold=1, state IDLE, and no further writes.
REQ-036 SHALL cover: start, then stream 0x03,0x1E,0x2F,0xE0 (plus checksum 0x2D if enabled) -> writes addr0=0x1E, addr1=0x2F, addr2=0xE0, then done=1 and cpu_hold=0.
REQ-037 SHALL cover: length byte 0x00, and separately 0x11 -> err=1, cpu_hold=1, no prog_we.
REQ-038 SHALL cover: N=16 back-to-back with ld_valid held high -> 16 consecutive prog_we cycles, addr 0..15, with no write to addr 0 after addr 15.
REQ-039 SHALL cover: ld_valid toggled randomly during DATA -> writes only for handshaked bytes, in order, each 1 cycle after its acceptance.
REQ-040 SHALL cover (with CHECKSUM_EN): stream 0x02,0x10,0x20,0x31 -> err=1; retry with checksum 0x30 after start -> done=1.
